// File: rtl/door_lock_pkg.sv
// door_lock_pkg: shared types and width helpers for the keypad door-lock
// controller.
//   state_e   - controller state encoding
//   dl_dw     - bits per digit for a given key count (minimum 1)
//   dl_cnt_w  - bits needed to count 0..n inclusive (minimum 1)
//   dl_max    - larger of two integers, used to size the shared timer
package door_lock_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNLOCKED,
        S_DENIED,
        S_LOCKOUT,
        S_NEW_CODE,
        S_CONFIRM_CODE
    } state_e;

    function automatic int dl_dw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int dl_cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int dl_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/door_lock_edge_detect.sv
// door_lock_edge_detect: registers a vector of inputs and flags per-bit
// transitions between the last two registered samples.
//   clk      - rising-edge clock
//   reset_n  - synchronous active-low reset; both samples load RST_VAL so no
//              spurious edge appears after reset
//   in_i     - raw (already synchronised) inputs
//   level_o  - registered input level
//   rise_o   - registered 0->1 transition, one cycle wide
//   fall_o   - registered 1->0 transition, one cycle wide
module door_lock_edge_detect #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] in_i,
    output logic [W-1:0] level_o,
    output logic [W-1:0] rise_o,
    output logic [W-1:0] fall_o
);

    logic [W-1:0] in_q;
    logic [W-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            in_q   <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            in_q   <= in_i;
            prev_q <= in_q;
        end
    end

    assign level_o = in_q;
    assign rise_o  = in_q & ~prev_q;
    assign fall_o  = ~in_q & prev_q;

endmodule

// File: rtl/door_lock_ctrl.sv
// door_lock_ctrl: keypad door-lock controller. Collects a CODE_LEN-digit
// entry from active-low keys, checks it against the stored code, drives the
// unlock / alarm indicators, enforces a wrong-attempt lockout and supports a
// change-and-confirm flow for replacing the stored code.
//   clk          - rising-edge clock
//   reset_n      - synchronous active-low reset
//   key          - active-low key buttons, key i enters digit i
//   enter        - rising edge submits the entry (IDLE, NEW_CODE)
//   change       - rising edge while unlocked starts a code change
//   confirm      - rising edge submits the confirmation entry
//   green_LED    - door unlocked (held through the change flow)
//   red_LED      - wrong code / confirmation mismatch, or lockout
//   green_led2   - one-cycle pulse when a new code is committed
//   entry_digits - entry buffer, digit 0 in the MSBs
//   entry_cnt    - digits entered so far
//   tries_left   - wrong attempts remaining before lockout
module door_lock_ctrl
    import door_lock_pkg::*;
#(
    parameter int CODE_LEN       = 4,
    parameter int NUM_KEYS       = 4,
    parameter logic [CODE_LEN*dl_dw(NUM_KEYS)-1:0] DEFAULT_CODE = '0,
    parameter int MAX_TRIES      = 3,
    parameter int UNLOCK_CYCLES  = 8,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [NUM_KEYS-1:0]                   key,
    input  logic                                  enter,
    input  logic                                  change,
    input  logic                                  confirm,
    output logic                                  green_LED,
    output logic                                  red_LED,
    output logic                                  green_led2,
    output logic [CODE_LEN*dl_dw(NUM_KEYS)-1:0]   entry_digits,
    output logic [dl_cnt_w(CODE_LEN)-1:0]         entry_cnt,
    output logic [dl_cnt_w(MAX_TRIES)-1:0]        tries_left
);

    localparam int DW  = dl_dw(NUM_KEYS);
    localparam int EW  = CODE_LEN * DW;
    localparam int CW  = dl_cnt_w(CODE_LEN);
    localparam int TW  = dl_cnt_w(MAX_TRIES);
    localparam int TMW = dl_cnt_w(dl_max(UNLOCK_CYCLES, LOCKOUT_CYCLES));

    // ---------------- input edge detection ----------------
    logic [NUM_KEYS-1:0] key_lvl, key_fall, key_rise_unused;
    logic [2:0]          ctl_rise, ctl_lvl_unused, ctl_fall_unused;

    door_lock_edge_detect #(.W(NUM_KEYS), .RST_VAL({NUM_KEYS{1'b1}})) u_key_ed (
        .clk     (clk),
        .reset_n (reset_n),
        .in_i    (key),
        .level_o (key_lvl),
        .rise_o  (key_rise_unused),
        .fall_o  (key_fall)
    );

    door_lock_edge_detect #(.W(3), .RST_VAL(3'b000)) u_ctl_ed (
        .clk     (clk),
        .reset_n (reset_n),
        .in_i    ({enter, change, confirm}),
        .level_o (ctl_lvl_unused),
        .rise_o  (ctl_rise),
        .fall_o  (ctl_fall_unused)
    );

    logic enter_rise, change_rise, confirm_rise;
    assign enter_rise   = ctl_rise[2];
    assign change_rise  = ctl_rise[1];
    assign confirm_rise = ctl_rise[0];

    // A press counts only when the falling key is the only key held low;
    // forcing the falling bit high must leave an all-ones level vector.
    logic          press_vld;
    logic [DW-1:0] press_digit;

    always_comb begin
        press_vld   = 1'b0;
        press_digit = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (key_fall[i] && ((key_lvl | (NUM_KEYS'(1) << i)) == {NUM_KEYS{1'b1}})) begin
                press_vld   = 1'b1;
                press_digit = DW'(i);
            end
        end
    end

    // ---------------- state and datapath registers ----------------
    state_e          state_q, state_d;
    logic [EW-1:0]   entry_q, entry_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic [EW-1:0]   code_q, code_d;
    logic [EW-1:0]   cand_q, cand_d;
    logic [TW-1:0]   tries_q, tries_d;
    logic [TMW-1:0]  timer_q, timer_d;
    logic            commit_q, commit_d;

    logic entry_full, entry_ok, accept;

    assign entry_full = (cnt_q == CW'(CODE_LEN));
    assign entry_ok   = entry_full && !ovf_q;
    // Enter in the same cycle as a press wins; the press is dropped.
    assign accept     = press_vld && !enter_rise &&
                        (state_q == S_IDLE || state_q == S_NEW_CODE ||
                         state_q == S_CONFIRM_CODE);

    always_comb begin
        state_d  = state_q;
        tries_d  = tries_q;
        code_d   = code_q;
        cand_d   = cand_q;
        commit_d = 1'b0;
        entry_d  = entry_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        timer_d  = timer_q;

        case (state_q)
            S_IDLE: begin
                if (enter_rise) begin
                    if (entry_ok && entry_q == code_q) begin
                        state_d = S_UNLOCKED;
                        tries_d = TW'(MAX_TRIES);
                    end else begin
                        state_d = S_DENIED;
                        if (tries_q != '0) tries_d = tries_q - TW'(1);
                    end
                end
            end
            S_UNLOCKED: begin
                if (change_rise)                                state_d = S_NEW_CODE;
                else if (timer_q == TMW'(UNLOCK_CYCLES - 1))    state_d = S_IDLE;
            end
            S_DENIED: begin
                state_d = (tries_q == '0) ? S_LOCKOUT : S_IDLE;
            end
            S_LOCKOUT: begin
                if (timer_q == TMW'(LOCKOUT_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    tries_d = TW'(MAX_TRIES);
                end
            end
            S_NEW_CODE: begin
                if (enter_rise) begin
                    if (entry_ok) begin
                        cand_d  = entry_q;
                        state_d = S_CONFIRM_CODE;
                    end else begin
                        state_d = S_DENIED;
                    end
                end
            end
            S_CONFIRM_CODE: begin
                if (confirm_rise) begin
                    if (entry_ok && entry_q == cand_q) begin
                        code_d   = cand_q;
                        commit_d = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        state_d  = S_DENIED;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Entry buffer and timer restart on every state change.
        if (state_d != state_q) begin
            entry_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            timer_d = '0;
        end else begin
            if (state_q == S_UNLOCKED || state_q == S_LOCKOUT)
                timer_d = timer_q + TMW'(1);
            if (accept) begin
                if (entry_full) begin
                    ovf_d = 1'b1;
                end else begin
                    for (int p = 0; p < CODE_LEN; p++)
                        if (cnt_q == CW'(p))
                            entry_d[(CODE_LEN-1-p)*DW +: DW] = press_digit;
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            entry_q  <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            code_q   <= DEFAULT_CODE;
            cand_q   <= '0;
            tries_q  <= TW'(MAX_TRIES);
            timer_q  <= '0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            entry_q  <= entry_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            code_q   <= code_d;
            cand_q   <= cand_d;
            tries_q  <= tries_d;
            timer_q  <= timer_d;
            commit_q <= commit_d;
        end
    end

    // ---------------- outputs ----------------
    assign green_LED    = (state_q == S_UNLOCKED) || (state_q == S_NEW_CODE) ||
                          (state_q == S_CONFIRM_CODE);
    assign red_LED      = (state_q == S_DENIED) || (state_q == S_LOCKOUT);
    assign green_led2   = commit_q;
    assign entry_digits = entry_q;
    assign entry_cnt    = cnt_q;
    assign tries_left   = tries_q;

endmodule

// File: tb/tb_door_lock_ctrl.sv
// tb_door_lock_ctrl: directed self-checking bench for door_lock_ctrl with
// DEFAULT_CODE = 0,1,2,3 (8'h1B). Inputs change 1 time unit after a rising
// edge and outputs are sampled at that same point.
module tb_door_lock_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] key;
    logic       enter, change, confirm;
    logic       green_LED, red_LED, green_led2;
    logic [7:0] entry_digits;
    logic [2:0] entry_cnt;
    logic [1:0] tries_left;

    int checks = 0;
    int errors = 0;

    door_lock_ctrl #(
        .CODE_LEN(4), .NUM_KEYS(4), .DEFAULT_CODE(8'h1B),
        .MAX_TRIES(3), .UNLOCK_CYCLES(8), .LOCKOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .key(key), .enter(enter),
        .change(change), .confirm(confirm), .green_LED(green_LED),
        .red_LED(red_LED), .green_led2(green_led2),
        .entry_digits(entry_digits), .entry_cnt(entry_cnt),
        .tries_left(tries_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int d);
        key    = 4'hF;
        key[d] = 1'b0;
        tick();
        key = 4'hF;
        tick();
    endtask

    task automatic enter_code(input logic [7:0] c);
        for (int i = 3; i >= 0; i--) press(int'(c[i*2 +: 2]));
    endtask

    task automatic pulse_enter();
        enter = 1'b1; tick(); enter = 1'b0; tick();
    endtask

    task automatic pulse_change();
        change = 1'b1; tick(); change = 1'b0; tick();
    endtask

    task automatic pulse_confirm();
        confirm = 1'b1; tick(); confirm = 1'b0; tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    // Counts consecutive cycles an LED stays high (bounded).
    task automatic count_high(input bit use_red, output int n);
        n = 0;
        while ((use_red ? red_LED : green_LED) && n < 64) begin
            n++;
            tick();
        end
    endtask

    int n;

    initial begin
        reset_n = 1'b0; key = 4'hF; enter = 0; change = 0; confirm = 0;
        tick(); tick();
        chk("rst_green", green_LED, 0);
        chk("rst_red",   red_LED, 0);
        chk("rst_led2",  green_led2, 0);
        chk("rst_cnt",   entry_cnt, 0);
        chk("rst_digits", entry_digits, 0);
        chk("rst_tries", tries_left, 3);
        reset_n = 1'b1;
        tick();

        // Correct code unlocks for 8 cycles.
        press(0);
        chk("cnt_after_1", entry_cnt, 1);
        chk("digits_after_1", entry_digits, 8'h00);
        press(1); press(2);
        chk("digits_after_3", entry_digits, 8'h18);
        press(3);
        chk("cnt_after_4", entry_cnt, 4);
        chk("digits_after_4", entry_digits, 8'h1B);
        pulse_enter();
        chk("unlock_green", green_LED, 1);
        chk("unlock_tries", tries_left, 3);
        chk("unlock_cnt_clr", entry_cnt, 0);
        count_high(1'b0, n);
        chk("unlock_len", n, 8);

        // Three wrong attempts lead to lockout.
        enter_code(8'h55); pulse_enter();
        chk("deny1_red", red_LED, 1);
        chk("deny1_tries", tries_left, 2);
        tick();
        chk("deny1_red_off", red_LED, 0);
        enter_code(8'h55); pulse_enter();
        chk("deny2_red", red_LED, 1);
        chk("deny2_tries", tries_left, 1);
        tick();
        chk("deny2_red_off", red_LED, 0);
        enter_code(8'h55); pulse_enter();
        chk("deny3_red", red_LED, 1);
        chk("deny3_tries", tries_left, 0);
        press(1); press(2); press(3);
        chk("lockout_cnt", entry_cnt, 0);
        count_high(1'b1, n);
        chk("lockout_rest_len", n, 17 - 6);
        chk("lockout_tries", tries_left, 3);

        // Change flow with mismatching confirmation.
        enter_code(8'h1B); pulse_enter();
        chk("cf1_unlock", green_LED, 1);
        pulse_change();
        chk("cf1_new_green", green_LED, 1);
        enter_code(8'hFA); pulse_enter();
        chk("cf1_confirm_green", green_LED, 1);
        enter_code(8'hF9); pulse_confirm();
        chk("cf1_mismatch_red", red_LED, 1);
        chk("cf1_mismatch_led2", green_led2, 0);
        chk("cf1_tries", tries_left, 3);
        tick();
        enter_code(8'h1B); pulse_enter();
        chk("cf1_old_code_ok", green_LED, 1);

        // Change flow that commits 3,3,2,2.
        pulse_change();
        enter_code(8'hFA); pulse_enter();
        enter_code(8'hFA); pulse_confirm();
        chk("cf2_led2", green_led2, 1);
        chk("cf2_green_off", green_LED, 0);
        tick();
        chk("cf2_led2_pulse", green_led2, 0);
        enter_code(8'h1B); pulse_enter();
        chk("cf2_old_denied", red_LED, 1);
        tick();
        enter_code(8'hFA); pulse_enter();
        chk("cf2_new_unlocks", green_LED, 1);
        chk("cf2_tries", tries_left, 3);
        count_high(1'b0, n);

        // Edge cases on the default code.
        do_reset();
        press(0); press(1); press(2); pulse_enter();
        chk("short_denied", red_LED, 1);
        chk("short_tries", tries_left, 2);
        tick();
        enter_code(8'h1B); press(3);
        chk("ovf_cnt", entry_cnt, 4);
        chk("ovf_digits", entry_digits, 8'h1B);
        pulse_enter();
        chk("ovf_denied", red_LED, 1);
        tick();
        key = 4'b1100; tick(); key = 4'hF; tick();
        chk("dual_press_cnt", entry_cnt, 0);
        enter_code(8'h1B); pulse_enter();
        chk("edge_unlock", green_LED, 1);
        count_high(1'b0, n);

        // Reset in the middle of lockout.
        for (int a = 0; a < 3; a++) begin
            enter_code(8'h00); pulse_enter(); tick();
        end
        tick(); tick();
        chk("mid_lockout_red", red_LED, 1);
        do_reset();
        chk("rst_lockout_red", red_LED, 0);
        chk("rst_lockout_tries", tries_left, 3);
        enter_code(8'h1B); pulse_enter();
        chk("rst_lockout_unlock", green_LED, 1);

        // Reset in the middle of the confirmation entry.
        pulse_change();
        enter_code(8'hFA); pulse_enter();
        press(3);
        chk("mid_confirm_cnt", entry_cnt, 1);
        do_reset();
        chk("rst_confirm_green", green_LED, 0);
        chk("rst_confirm_cnt", entry_cnt, 0);
        chk("rst_confirm_led2", green_led2, 0);
        enter_code(8'h1B); pulse_enter();
        chk("rst_confirm_default", green_LED, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
